train_led_encoder: RTL and testbench

//  Upstream frame encoder for the daisy-chained LED node string. Accepts 12-bit

---
 rtl/train_enc_pkg.sv | 19 +
 rtl/train_enc_cell.sv | 43 ++++
 rtl/train_led_encoder.sv | 118 +++++++++++
 tb/tb_train_led_encoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/train_enc_pkg.sv
// Shared types and constants for the LED string frame encoder.
package train_enc_pkg;
  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_e;

  localparam int HI_END         = 3;
  localparam int DATA_END       = 7;
  localparam int LATCH_CLKS_DEF = 128;

  // Entry i lives at bits [4*i +: 4].
  localparam logic [63:0] GAMMA_TBL = {4'd15, 4'd13, 4'd11, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4,
                                       4'd3,  4'd2,  4'd2,  4'd1, 4'd1, 4'd0, 4'd0, 4'd0};

  function automatic logic [11:0] gamma_word(input logic [11:0] w);
    logic [11:0] g;
    g = '0;
    for (int n = 0; n < 3; n++) g[4*n +: 4] = GAMMA_TBL[4*w[4*n +: 4] +: 4];
    return g;
  endfunction
endpackage

// File: rtl/train_enc_cell.sv
// Bit-cell timer: counts cell clocks and produces the registered line level
// (high start phase, data phase, low phase) plus an end-of-cell strobe.
module train_enc_cell
  import train_enc_pkg::*;
#(
  parameter int CELL_CLKS = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic data_bit,
  output logic line,
  output logic end_of_cell
);
  localparam int CW = $clog2(CELL_CLKS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          line_q, line_d;

  assign end_of_cell = run && (cnt_q == CW'(CELL_CLKS - 1));
  assign line        = line_q;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    line_d = 1'b0;
    if (start || !run || end_of_cell) cnt_d = '0;
    if (run) begin
      if (cnt_q <= CW'(HI_END))        line_d = 1'b1;
      else if (cnt_q <= CW'(DATA_END)) line_d = data_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end
endmodule

// File: rtl/train_led_encoder.sv
// Frame encoder for the daisy-chained LED string: serialises 12-bit words as
// pulse cells, then holds a low latch gap. Optional TRAIN_ENC_GAMMA_EN maps nibbles at capture.
module train_led_encoder
  import train_enc_pkg::*;
#(
  parameter int WORD_W     = 12,
  parameter int CELL_CLKS  = 12,
  parameter int LATCH_CLKS = LATCH_CLKS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);
  localparam int BW = $clog2(WORD_W);
  localparam int LW = $clog2(LATCH_CLKS);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d, cap_word;
  logic [BW-1:0]     bit_q, bit_d;
  logic [LW-1:0]     lcnt_q, lcnt_d;
  logic              last_q, last_d;
  logic              frame_done_q, frame_done_d;
  logic              underrun_q, underrun_d;
  logic              accept, eoc;

`ifdef TRAIN_ENC_GAMMA_EN
  assign cap_word = gamma_word(in_data);
`else
  assign cap_word = in_data;
`endif

  train_enc_cell #(.CELL_CLKS(CELL_CLKS)) u_cell (
    .clk        (clk),
    .rst        (rst),
    .start      (accept),
    .run        (state_q == SEND),
    .data_bit   (shreg_q[WORD_W-1]),
    .line       (dout),
    .end_of_cell(eoc)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_d        = bit_q;
    last_d       = last_q;
    lcnt_d       = '0;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    in_ready     = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      SEND: begin
        if (eoc) begin
          if (bit_q == '0) begin
            // Final clock of the word: a non-last word may chain straight on.
            in_ready = !last_q;
            if (last_q || !in_valid) begin
              state_d    = LATCH;
              underrun_d = !last_q;
            end
          end else begin
            bit_d   = bit_q - 1'b1;
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
          end
        end
      end
      LATCH: begin
        lcnt_d = lcnt_q + 1'b1;
        if (lcnt_q == LW'(LATCH_CLKS - 1)) begin
          lcnt_d       = '0;
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
    accept = in_valid && in_ready;
    if (accept) begin
      state_d = SEND;
      shreg_d = cap_word;
      last_d  = in_last;
      bit_d   = BW'(WORD_W - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_q        <= '0;
      last_q       <= 1'b0;
      lcnt_q       <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_q        <= bit_d;
      last_q       <= last_d;
      lcnt_q       <= lcnt_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
endmodule

// File: tb/tb_train_led_encoder.sv
// Directed bench for train_led_encoder with a two-node LED chain decoder model.
module tb_train_led_encoder;
  logic        clk = 1'b0;
  logic        rst, in_last, in_valid;
  logic [11:0] in_data;
  logic        in_ready, dout, busy, frame_done, underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  train_led_encoder dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  // Two-node chain: node1 keeps the first 12 decoded bits, node2 the next 12;
  // both latch after 96 low clocks.
  logic        prev_dout = 1'b0;
  int          pos = 1000, bits_seen = 0, low_run = 0;
  int          cur_pos;
  logic [11:0] n1_sr = '0, n2_sr = '0, n1_lat = '0, n2_lat = '0;

  assign cur_pos = (dout && !prev_dout) ? 0 : pos + 1;

  always @(posedge clk) begin
    prev_dout <= dout;
    pos       <= cur_pos;
    low_run   <= dout ? 0 : low_run + 1;
    if (cur_pos == 5) begin
      if (bits_seen < 12)      n1_sr <= {n1_sr[10:0], dout};
      else if (bits_seen < 24) n2_sr <= {n2_sr[10:0], dout};
      bits_seen <= bits_seen + 1;
    end
    if (!dout && low_run == 95 && bits_seen != 0) begin
      n1_lat    <= n1_sr;
      n2_lat    <= n2_sr;
      bits_seen <= 0;
    end
  end

  logic        r_dout [0:1023];
  logic        r_rdy  [0:1023];
  logic        r_fd   [0:1023];
  logic        r_ur   [0:1023];
  logic        r_busy [0:1023];
  logic [11:0] q_d [$];
  logic        q_l [$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_word(input logic [11:0] w);
`ifdef TRAIN_ENC_GAMMA_EN
    logic [3:0] g [0:15];
    g = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3,
          4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
    return {g[w[11:8]], g[w[7:4]], g[w[3:0]]};
`else
    return w;
`endif
  endfunction

  task automatic send_frame();
    in_data  = q_d[0];
    in_last  = q_l[0];
    in_valid = 1'b1;
  endtask

  // Index i holds the period i-1 clocks after the first accept edge.
  task automatic run(input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      r_dout[i] = dout; r_rdy[i] = in_ready; r_fd[i] = frame_done;
      r_ur[i]   = underrun; r_busy[i] = busy;
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        void'(q_d.pop_front());
        void'(q_l.pop_front());
        if (q_d.size() > 0) begin
          in_data = q_d[0];
          in_last = q_l[0];
        end else in_valid = 1'b0;
      end
    end
  endtask

  task automatic chk_cells(input string tag, input logic [11:0] w, input int s);
    logic [11:0] pat, exp;
    for (int k = 0; k < 12; k++) begin
      pat = '0;
      for (int c = 0; c < 12; c++) pat = {pat[10:0], r_dout[s + 12*k + c]};
      exp = {4'hF, {4{w[11-k]}}, 4'h0};
      chk($sformatf("%s_cell%0d", tag, k), 32'(pat), 32'(exp));
    end
  endtask

  task automatic wait_fd(input string tag);
    for (int i = 0; i < 400 && !frame_done; i++) step();
    chk(tag, 32'(frame_done), 32'd1);
    step();
  endtask

  task automatic count(input string tag, ref logic arr [0:1023], input int lo, input int hi,
                       input int exp);
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) if (arr[i]) n++;
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    logic [11:0] w;
    rst = 1'b1; in_valid = 1'b1; in_data = 12'hFFF; in_last = 1'b0;
    step(); step(); step();
    chk("rst_dout", 32'(dout), 0);
    chk("rst_rdy", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_ur", 32'(underrun), 0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("idle_rdy", 32'(in_ready), 1);

    // 1: single last word
    q_d.push_back(12'hA5C); q_l.push_back(1'b1);
    send_frame();
    run(280);
    chk("t1_lat0", 32'(r_dout[1]), 0);
    chk("t1_lat1", 32'(r_dout[2]), 1);
    chk_cells("t1", exp_word(12'hA5C), 2);
    chk("t1_rdy143", 32'(r_rdy[144]), 0);
    count("t1_gap_low", r_dout, 146, 273, 0);
    count("t1_fd_early", r_fd, 0, 272, 0);
    chk("t1_fd272", 32'(r_fd[273]), 1);
    chk("t1_rdy272", 32'(r_rdy[273]), 1);
    chk("t1_busy272", 32'(r_busy[273]), 0);

    // 2: three back-to-back words
    q_d.push_back(12'h123); q_l.push_back(1'b0);
    q_d.push_back(12'h456); q_l.push_back(1'b0);
    q_d.push_back(12'h789); q_l.push_back(1'b1);
    send_frame();
    run(440);
    chk_cells("t2w0", exp_word(12'h123), 2);
    chk_cells("t2w1", exp_word(12'h456), 146);
    chk_cells("t2w2", exp_word(12'h789), 290);
    chk("t2_rdy143", 32'(r_rdy[144]), 1);
    chk("t2_rdy287", 32'(r_rdy[288]), 1);
    count("t2_rdy_cnt", r_rdy, 1, 432, 2);
    count("t2_ur", r_ur, 0, 439, 0);
    wait_fd("t2_fd");

    // 3: underrun after a non-last word
    q_d.push_back(12'h0FF); q_l.push_back(1'b0);
    send_frame();
    run(170);
    chk_cells("t3", exp_word(12'h0FF), 2);
    chk("t3_rdy143", 32'(r_rdy[144]), 1);
    chk("t3_ur144", 32'(r_ur[145]), 1);
    count("t3_ur_cnt", r_ur, 0, 169, 1);
    count("t3_low", r_dout, 146, 169, 0);
    chk("t3_busy", 32'(r_busy[160]), 1);
    wait_fd("t3_fd");

    // 4: reset in cell 5, held with in_valid asserted
    q_d.push_back(12'hFFF); q_l.push_back(1'b1);
    send_frame();
    run(66);
    chk("t4_busy_pre", 32'(r_busy[65]), 1);
    rst = 1'b1; in_valid = 1'b1;
    step();
    chk("t4_dout", 32'(dout), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_rdy_rst", 32'(in_ready), 0);
    step();
    chk("t4_busy_hold", 32'(busy), 0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("t4_rdy_after", 32'(in_ready), 1);
    chk("t4_dout_after", 32'(dout), 0);
    for (int i = 0; i < 120; i++) step();

    // 5: two chained nodes
    q_d.push_back(12'h123); q_l.push_back(1'b0);
    q_d.push_back(12'hFED); q_l.push_back(1'b1);
    send_frame();
    run(300);
    wait_fd("t5_fd");
    chk("t5_node1", 32'(n1_lat), 32'(exp_word(12'h123)));
    chk("t5_node2", 32'(n2_lat), 32'(exp_word(12'hFED)));

    // 6: gamma mapping on capture
    q_d.push_back(12'hF84); q_l.push_back(1'b1);
    send_frame();
    run(150);
    w = '0;
    for (int k = 0; k < 12; k++) w = {w[10:0], r_dout[2 + 12*k + 5]};
`ifdef TRAIN_ENC_GAMMA_EN
    chk("t6_gamma", 32'(w), 32'h0F41);
`else
    chk("t6_plain", 32'(w), 32'h0F84);
`endif
    wait_fd("t6_fd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
